// File: rtl/pc_pkg.sv
// Shared types for the fetch-stage program-counter sequencer.
package pc_pkg;
  typedef enum logic [2:0] {
    SEQ  = 3'd0,
    REL  = 3'd1,
    ABS  = 3'd2,
    CALL = 3'd3,
    RET  = 3'd4,
    TRAP = 3'd5
  } pc_mode_e;

  typedef enum logic [1:0] {BOOT, RUN, HALTED} pc_state_e;
endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a full push overwrites the oldest entry.
module pc_ras #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            Clock,
  input  logic            nReset,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            full,
  output logic            empty,
  output logic            overflow
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW:0]   CNT_MAX = (PW+1)'(RAS_DEPTH);

  logic [RAS_DEPTH-1:0][XLEN-1:0] mem;
  logic [PW-1:0] ptr, ptr_m1;
  logic [PW:0]   cnt;

  // ptr addresses the next free slot; when full that slot is the oldest entry
  assign ptr_m1   = ptr - PTR_ONE;
  assign top      = mem[ptr_m1];
  assign full     = (cnt == CNT_MAX);
  assign empty    = (cnt == '0);
  assign overflow = push & full;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      mem <= '0;
      ptr <= '0;
      cnt <= '0;
    end else if (push) begin
      mem[ptr] <= push_data;
      ptr      <= ptr + PTR_ONE;
      if (!full) cnt <= cnt + CNT_ONE;
    end else if (pop && !empty) begin
      ptr <= ptr_m1;
      cnt <= cnt - CNT_ONE;
    end
  end
endmodule

// File: rtl/pc_sequencer.sv
// Fetch-head PC sequencer: run/halt FSM, next-PC mux, alignment check, sticky error flags.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
  parameter logic [XLEN-1:0] INC          = XLEN'(4),
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            Clock,
  input  logic            nReset,
  input  logic            Advance,
  input  logic [2:0]      Mode,
  input  logic [XLEN-1:0] PCin,
  input  logic            Halt,
  input  logic            Resume,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCnext,
  output logic            Running,
  output logic            Misaligned,
  output logic            RasOverflow,
  output logic            RasUnderflow
);
  pc_state_e       state;
  logic [XLEN-1:0] target, pc_nxt, ras_top;
  logic            tgt_chk, bad, upd, push, pop, ret_empty;
  logic            ras_full, ras_empty, ras_ovf;

  assign PCnext  = PC + INC;
  assign Running = (state == RUN);
  assign upd     = (state == RUN) && Advance && !Halt;

  always_comb begin
    target  = PCin;
    tgt_chk = 1'b0;
    case (Mode)
      REL:       begin target = PC + PCin; tgt_chk = 1'b1; end
      ABS, CALL: tgt_chk = 1'b1;
      default:   ;
    endcase
  end

  assign bad       = tgt_chk && (target[1:0] != 2'b00);
  assign ret_empty = (Mode == RET) && ras_empty;
  assign push      = upd && (Mode == CALL) && !bad;
  assign pop       = upd && (Mode == RET) && !ras_empty;

  always_comb begin
    pc_nxt = PCnext;
    case (Mode)
      REL, ABS, CALL: pc_nxt = bad ? TRAP_VECTOR : target;
      RET:            pc_nxt = ras_empty ? TRAP_VECTOR : ras_top;
      TRAP:           pc_nxt = TRAP_VECTOR;
      default:        ;
    endcase
  end

  pc_ras #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .Clock     (Clock),
    .nReset    (nReset),
    .push      (push),
    .pop       (pop),
    .push_data (PCnext),
    .top       (ras_top),
    .full      (ras_full),
    .empty     (ras_empty),
    .overflow  (ras_ovf)
  );

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state        <= BOOT;
      PC           <= RESET_VECTOR;
      Misaligned   <= 1'b0;
      RasOverflow  <= 1'b0;
      RasUnderflow <= 1'b0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (Halt) state <= HALTED;
          else if (Advance) begin
            PC <= pc_nxt;
            if (bad)       Misaligned   <= 1'b1;
            if (ras_ovf)   RasOverflow  <= 1'b1;
            if (ret_empty) RasUnderflow <= 1'b1;
          end
        end
        HALTED: if (Resume && !Halt) state <= RUN;
        default: state <= BOOT;
      endcase
    end
  end

  logic unused_full;
  assign unused_full = ras_full;
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expected PC/flag tuples queued per cycle, compared after the edge.
module tb_pc_sequencer;
  import pc_pkg::*;

  logic        Clock = 1'b0, nReset = 1'b0;
  logic        Advance = 1'b0, Halt = 1'b0, Resume = 1'b0;
  logic [2:0]  Mode = 3'd0;
  logic [31:0] PCin = '0;
  logic [31:0] PC, PCnext;
  logic        Running, Misaligned, RasOverflow, RasUnderflow;

  typedef struct {
    logic [31:0] pc;
    logic        run, mis, ovf, unf;
  } exp_t;

  exp_t sb[$];
  int   npass = 0, ntot = 0;
  logic exp_mis = 1'b0, exp_ovf = 1'b0, exp_unf = 1'b0;

  pc_sequencer dut (
    .Clock(Clock), .nReset(nReset), .Advance(Advance), .Mode(Mode), .PCin(PCin),
    .Halt(Halt), .Resume(Resume), .PC(PC), .PCnext(PCnext), .Running(Running),
    .Misaligned(Misaligned), .RasOverflow(RasOverflow), .RasUnderflow(RasUnderflow)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else npass++;
  endtask

  task automatic cmp_all(input string tag, input exp_t e);
    chk({tag, ".pc"},     PC, e.pc);
    chk({tag, ".pcnext"}, PCnext, e.pc + 32'd4);
    chk({tag, ".run"},    32'(Running), 32'(e.run));
    chk({tag, ".mis"},    32'(Misaligned), 32'(e.mis));
    chk({tag, ".ovf"},    32'(RasOverflow), 32'(e.ovf));
    chk({tag, ".unf"},    32'(RasUnderflow), 32'(e.unf));
  endtask

  // drive one cycle of stimulus, queue its expectation, compare after the edge
  task automatic cyc(input string tag, input logic [2:0] m, input logic [31:0] pin,
                     input logic adv, input logic hlt, input logic res,
                     input logic [31:0] epc, input logic erun);
    exp_t e;
    Mode = m; PCin = pin; Advance = adv; Halt = hlt; Resume = res;
    sb.push_back('{pc: epc, run: erun, mis: exp_mis, ovf: exp_ovf, unf: exp_unf});
    @(posedge Clock); #1;
    e = sb.pop_front();
    cmp_all(tag, e);
  endtask

  initial begin
    exp_t r;
    // reset state
    repeat (2) @(posedge Clock);
    #1;
    r = '{pc: 32'h0, run: 1'b0, mis: 1'b0, ovf: 1'b0, unf: 1'b0};
    cmp_all("reset", r);
    @(negedge Clock); nReset = 1'b1;

    // boot then sequential
    cyc("boot", SEQ, 0, 1, 0, 0, 32'h0, 1);
    cyc("seq1", SEQ, 0, 1, 0, 0, 32'h4, 1);
    cyc("seq2", SEQ, 0, 1, 0, 0, 32'h8, 1);
    cyc("seq3", SEQ, 0, 1, 0, 0, 32'hC, 1);

    // relative / absolute / misaligned
    cyc("abs10", ABS, 32'h10, 1, 0, 0, 32'h10, 1);
    cyc("relm8", REL, 32'hFFFF_FFF8, 1, 0, 0, 32'h8, 1);
    cyc("abs200", ABS, 32'h200, 1, 0, 0, 32'h200, 1);
    exp_mis = 1'b1;
    cyc("abs202", ABS, 32'h202, 1, 0, 0, 32'h100, 1);

    // call / return / underflow
    cyc("abs20", ABS, 32'h20, 1, 0, 0, 32'h20, 1);
    cyc("call400", CALL, 32'h400, 1, 0, 0, 32'h400, 1);
    cyc("seq404", SEQ, 0, 1, 0, 0, 32'h404, 1);
    cyc("ret24", RET, 0, 1, 0, 0, 32'h24, 1);
    exp_unf = 1'b1;
    cyc("ret_empty", RET, 0, 1, 0, 0, 32'h100, 1);

    // five calls into a depth-4 stack
    cyc("callA", CALL, 32'h1000, 1, 0, 0, 32'h1000, 1);
    cyc("callB", CALL, 32'h2000, 1, 0, 0, 32'h2000, 1);
    cyc("callC", CALL, 32'h3000, 1, 0, 0, 32'h3000, 1);
    cyc("callD", CALL, 32'h4000, 1, 0, 0, 32'h4000, 1);
    exp_ovf = 1'b1;
    cyc("callE", CALL, 32'h5000, 1, 0, 0, 32'h5000, 1);
    cyc("retE", RET, 0, 1, 0, 0, 32'h4004, 1);
    cyc("retD", RET, 0, 1, 0, 0, 32'h3004, 1);
    cyc("retC", RET, 0, 1, 0, 0, 32'h2004, 1);
    cyc("retB", RET, 0, 1, 0, 0, 32'h1004, 1);
    cyc("retA", RET, 0, 1, 0, 0, 32'h100, 1);

    // stall, halt, resume
    for (int i = 0; i < 3; i++) cyc("stall", SEQ, 0, 0, 0, 0, 32'h100, 1);
    cyc("halt", ABS, 32'h800, 1, 1, 0, 32'h100, 0);
    cyc("halt_res", SEQ, 0, 1, 1, 1, 32'h100, 0);
    cyc("resume", SEQ, 0, 1, 0, 1, 32'h100, 1);
    cyc("seq_run", SEQ, 0, 1, 0, 0, 32'h104, 1);

    // wrap at top of address space
    cyc("abs_top", ABS, 32'hFFFF_FFFC, 1, 0, 0, 32'hFFFF_FFFC, 1);
    cyc("seq_wrap", SEQ, 0, 1, 0, 0, 32'h0, 1);

    // reset asserted mid-CALL
    cyc("pre_call", CALL, 32'h600, 1, 0, 0, 32'h600, 1);
    Mode = CALL; PCin = 32'h700; Advance = 1'b1;
    #2 nReset = 1'b0;
    #1;
    exp_mis = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;
    r = '{pc: 32'h0, run: 1'b0, mis: 1'b0, ovf: 1'b0, unf: 1'b0};
    cmp_all("midreset", r);
    @(negedge Clock); nReset = 1'b1;
    cyc("boot2", SEQ, 0, 1, 0, 0, 32'h0, 1);
    exp_unf = 1'b1;
    cyc("ret_after_rst", RET, 0, 1, 0, 0, 32'h100, 1);

    // trap leaves RAS intact, undefined mode acts as SEQ
    cyc("abs40", ABS, 32'h40, 1, 0, 0, 32'h40, 1);
    cyc("call80", CALL, 32'h80, 1, 0, 0, 32'h80, 1);
    cyc("trap", TRAP, 32'h999, 1, 0, 0, 32'h100, 1);
    cyc("undef7", 3'd7, 32'h999, 1, 0, 0, 32'h104, 1);
    cyc("ret44", RET, 0, 1, 0, 0, 32'h44, 1);

    // misaligned CALL traps and does not push
    exp_mis = 1'b1;
    cyc("call_mis", CALL, 32'h401, 1, 0, 0, 32'h100, 1);
    cyc("ret_nopush", RET, 0, 1, 0, 0, 32'h100, 1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
